// File: rtl/param_updown_counter_pkg.sv
// rtl/param_updown_counter_pkg.sv - shared constants and helpers for the up/down counter
package param_updown_counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Limits a requested count to the terminal value; callers size to WIDTH.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                               input logic [31:0] max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/sticky_flag.sv
// rtl/sticky_flag.sv - set/clear flag register where a set beats a simultaneous clear
module sticky_flag (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clear,
  output logic flag
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag <= 1'b0;
    end else if (set) begin
      flag <= 1'b1;
    end else if (clear) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parametrised up/down counter with wrap/saturate, event pulses and sticky flags
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int                WIDTH     = 4,
  parameter longint unsigned   MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter int                SATURATE  = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] counter_out,
  output logic             terminal_out,
  output logic             ovf_pulse,
  output logic             unf_pulse,
  output logic             overflow_out,
  output logic             underflow_out
);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("param_updown_counter: WIDTH must be in 2..32");
    end
    if (MAX_VALUE < 64'd1 || MAX_VALUE > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("param_updown_counter: MAX_VALUE must be in 1..2**WIDTH-1");
    end
    if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
      $error("param_updown_counter: SATURATE must be 0 or 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] next_count;
  logic             ovf_event;
  logic             unf_event;
  logic             at_max;
  logic             at_zero;

  assign at_max       = (counter_out == MAX_V);
  assign at_zero      = (counter_out == '0);
  assign terminal_out = up_down ? at_max : at_zero;

  always_comb begin
    next_count = counter_out;
    ovf_event  = 1'b0;
    unf_event  = 1'b0;
    if (load) begin
      next_count = WIDTH'(clamp_to_max(32'(load_value), 32'(MAX_V)));
    end else if (enable) begin
      if (up_down) begin
        if (at_max) begin
          ovf_event  = 1'b1;
          next_count = (SATURATE == CNT_SAT) ? MAX_V : '0;
        end else begin
          next_count = counter_out + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          unf_event  = 1'b1;
          next_count = (SATURATE == CNT_SAT) ? '0 : MAX_V;
        end else begin
          next_count = counter_out - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_out <= '0;
      ovf_pulse   <= 1'b0;
      unf_pulse   <= 1'b0;
    end else begin
      counter_out <= next_count;
      ovf_pulse   <= ovf_event;
      unf_pulse   <= unf_event;
    end
  end

  sticky_flag u_ovf_flag (
    .clk   (clk),
    .reset (reset),
    .set   (ovf_event),
    .clear (clear_flags),
    .flag  (overflow_out)
  );

  sticky_flag u_unf_flag (
    .clk   (clk),
    .reset (reset),
    .set   (unf_event),
    .clear (clear_flags),
    .flag  (underflow_out)
  );

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - self-checking bench for param_updown_counter (wrap MAX=9 and saturate MAX=15)
module tb_param_updown_counter;

  localparam int MX[2] = '{9, 15};
  localparam int ST[2] = '{0, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up_down = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       clear_flags = 1'b0;

  logic [3:0] d_cnt[2];
  logic       d_term[2];
  logic       d_ovp[2];
  logic       d_unp[2];
  logic       d_ovf[2];
  logic       d_unf[2];

  int  m_cnt[2];
  bit  m_ovp[2];
  bit  m_unp[2];
  bit  m_ovf[2];
  bit  m_unf[2];
  bit  started = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear_flags(clear_flags), .counter_out(d_cnt[0]),
    .terminal_out(d_term[0]), .ovf_pulse(d_ovp[0]), .unf_pulse(d_unp[0]),
    .overflow_out(d_ovf[0]), .underflow_out(d_unf[0])
  );

  param_updown_counter #(.WIDTH(4), .MAX_VALUE(15), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear_flags(clear_flags), .counter_out(d_cnt[1]),
    .terminal_out(d_term[1]), .ovf_pulse(d_ovp[1]), .unf_pulse(d_unp[1]),
    .overflow_out(d_ovf[1]), .underflow_out(d_unf[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: integer count with explicit limit rules.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      started <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] <= 0; m_ovp[i] <= 0; m_unp[i] <= 0; m_ovf[i] <= 0; m_unf[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int nc;
        bit eo;
        bit eu;
        nc = m_cnt[i];
        eo = 0;
        eu = 0;
        if (load) nc = (int'(load_value) > MX[i]) ? MX[i] : int'(load_value);
        else if (enable && up_down) begin
          if (m_cnt[i] == MX[i]) begin eo = 1; nc = ST[i] ? MX[i] : 0; end
          else nc = m_cnt[i] + 1;
        end else if (enable) begin
          if (m_cnt[i] == 0) begin eu = 1; nc = ST[i] ? 0 : MX[i]; end
          else nc = m_cnt[i] - 1;
        end
        m_cnt[i] <= nc;
        m_ovp[i] <= eo;
        m_unp[i] <= eu;
        m_ovf[i] <= eo ? 1'b1 : (clear_flags ? 1'b0 : m_ovf[i]);
        m_unf[i] <= eu ? 1'b1 : (clear_flags ? 1'b0 : m_unf[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cnt[%0d]", i), int'(d_cnt[i]), m_cnt[i]);
        chk($sformatf("term[%0d]", i), int'(d_term[i]),
            int'((up_down && m_cnt[i] == MX[i]) || (!up_down && m_cnt[i] == 0)));
        chk($sformatf("ovf_pulse[%0d]", i), int'(d_ovp[i]), int'(m_ovp[i]));
        chk($sformatf("unf_pulse[%0d]", i), int'(d_unp[i]), int'(m_unp[i]));
        chk($sformatf("overflow[%0d]", i), int'(d_ovf[i]), int'(m_ovf[i]));
        chk($sformatf("underflow[%0d]", i), int'(d_unf[i]), int'(m_unf[i]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int exp_up[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("reset_cnt", int'(d_cnt[0]), 0);
    chk("reset_ovp", int'(d_ovp[0]), 0);
    chk("reset_flags", int'({d_ovf[0], d_unf[0]}), 0);
    cyc();
    reset = 1'b1;

    // Wrap counter counts 0..9,0,1 with one overflow pulse on the wrap.
    enable = 1'b1; up_down = 1'b1;
    for (int k = 0; k < 11; k++) begin
      cyc();
      chk($sformatf("up_seq_%0d", k), int'(d_cnt[0]), exp_up[k]);
      chk($sformatf("up_ovp_%0d", k), int'(d_ovp[0]), (k == 9) ? 1 : 0);
    end
    chk("up_overflow_sticky", int'(d_ovf[0]), 1);
    chk("sat_up_11", int'(d_cnt[1]), 11);

    enable = 1'b0; load = 1'b1; load_value = 4'd0;
    cyc();
    load = 1'b0; enable = 1'b1; up_down = 1'b0;
    cyc();
    chk("down_wrap_cnt", int'(d_cnt[0]), 9);
    chk("down_wrap_unp", int'(d_unp[0]), 1);
    chk("down_wrap_unf", int'(d_unf[0]), 1);
    chk("sat_down_hold", int'(d_cnt[1]), 0);
    enable = 1'b0;
    cyc();
    chk("unp_one_cycle", int'(d_unp[0]), 0);
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    chk("clear_flags", int'({d_ovf[0], d_unf[0]}), 0);

    // Saturating counter holds at 15 and pulses on every enabled step.
    load = 1'b1; load_value = 4'd15;
    cyc();
    chk("load_clamp_15", int'(d_cnt[0]), 9);
    load = 1'b0; enable = 1'b1; up_down = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("sat_hold_%0d", k), int'(d_cnt[1]), 15);
      chk($sformatf("sat_ovp_%0d", k), int'(d_ovp[1]), 1);
      chk($sformatf("sat_term_%0d", k), int'(d_term[1]), 1);
    end

    // Load beats enable and is clamped; next step overflows.
    load = 1'b1; load_value = 4'd14;
    cyc();
    chk("load_clamp_14", int'(d_cnt[0]), 9);
    chk("load_no_pulse", int'({d_ovp[0], d_unp[0]}), 0);
    load = 1'b0;
    cyc();
    chk("after_load_wrap", int'(d_cnt[0]), 0);
    chk("after_load_ovp", int'(d_ovp[0]), 1);

    // Overflow coinciding with clear_flags leaves the flag set.
    enable = 1'b0; clear_flags = 1'b1;
    cyc();
    chk("pre_set_wins_clear", int'(d_ovf[0]), 0);
    load = 1'b1; load_value = 4'd9;
    cyc();
    load = 1'b0; enable = 1'b1;
    cyc();
    chk("set_wins", int'(d_ovf[0]), 1);
    clear_flags = 1'b0; enable = 1'b0;

    // Asynchronous reset between edges.
    load = 1'b1; load_value = 4'd7;
    cyc();
    load = 1'b0;
    chk("pre_reset_cnt", int'(d_cnt[0]), 7);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_cnt", int'(d_cnt[0]), 0);
    chk("async_reset_flag", int'(d_ovf[0]), 0);
    chk("async_reset_sat", int'(d_cnt[1]), 0);
    enable = 1'b1; up_down = 1'b1;
    @(negedge clk);
    #1 reset = 1'b1;
    cyc();
    chk("resume_cnt", int'(d_cnt[0]), 1);
    chk("resume_sat", int'(d_cnt[1]), 1);
    enable = 1'b0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
